simple_mem_responder: RTL
=========================

// Module: simple_mem_responder
// PURPOSE
//   Memory-side responder for the SIMPLE multi-phase CPU. Accepts one read or
//   write request at a time from the CPU (initiator), inserts a configurable
//   number of wait states, then acknowledges with a one-cycle ack pulse.
//   Contains the unified instruction/data RAM, a memory-mapped I/O word
//   (io_in/io_out), and a program-loader write port used before exec.
// PARAMETERS
//   ADDR_W       12      word-address width; RAM depth = 2**ADDR_W words
//   DATA_W       16      data word width
//   WAIT_CYCLES  1       wait states inserted before ack, legal range 0..15
//   IO_ADDR      'hFFF   address decoded as the I/O word instead of RAM
// PORTS
//   clk      in   1       clock, all state updates on posedge
//   rst_n    in   1       asynchronous, active-low reset
//   req      in   1       CPU access request, held high until ack
//   we       in   1       1 = write, 0 = read; sampled with req
//   addr     in   ADDR_W  word address; sampled with req
//   wdata    in   DATA_W  write data; sampled with req
//   rdata    out  DATA_W  read data; valid while ack = 1, held until next read ack
//   ack      out  1       one-cycle completion pulse
//   busy     out  1       1 while an access is in WAIT or ACK
//   ld_we    in   1       loader write strobe
//   ld_addr  in   ADDR_W  loader write address
//   ld_data  in   DATA_W  loader write data
//   ld_rdy   out  1       1 when a loader write is accepted this cycle (state IDLE)
//   io_in    in   DATA_W  external input word, read at IO_ADDR
//   io_out   out  DATA_W  external output register, written at IO_ADDR
// BEHAVIOUR
//   Reset: state=IDLE, ack=0, busy=0, rdata=0, io_out=0, wait counter=0.
//     RAM contents are not cleared. Reset mid-access aborts the access, and a
//     write not yet committed is lost.
//   FSM IDLE -> WAIT -> ACK -> IDLE. With WAIT_CYCLES=0, IDLE goes straight to ACK.
//   IDLE: if req=1 and ld_we=0, latch we/addr/wdata and load counter with
//     WAIT_CYCLES. Go to WAIT, or to ACK if WAIT_CYCLES=0.
//   WAIT: decrement counter each cycle. On the edge where counter reaches 1,
//     go to ACK.
//   Latency: ack is high exactly WAIT_CYCLES+1 cycles after the edge that
//     sampled req.
//   Commit happens on the edge entering ACK, using the latched fields:
//     - write to RAM: RAM[addr] <= wdata
//     - write to IO_ADDR: io_out <= wdata; RAM is not written
//     - read from RAM: rdata <= RAM[addr]
//     - read from IO_ADDR: rdata <= io_in as sampled on that edge
//     - any write leaves rdata unchanged
//   ACK: ack=1 for one cycle, then return to IDLE unconditionally. req seen
//     during ACK is ignored. A req still high in the following IDLE cycle is a
//     new request (back-to-back accesses are allowed).
//   req, we, addr and wdata changes during WAIT/ACK have no effect.
//     Dropping req before ack does not cancel the access.
//   busy = (state != IDLE). ld_rdy = (state == IDLE).
//   Loader: if ld_we=1 and state=IDLE, then RAM[ld_addr] <= ld_data on that
//     edge. ld_addr=IO_ADDR writes io_out instead of RAM.
//   Loader vs CPU: if ld_we and req are both high in IDLE, the loader write
//     wins and req is not accepted; req is accepted on a later IDLE cycle.
//   ld_we while busy is dropped; the loader must check ld_rdy.
//   Address wrap: addr is exactly ADDR_W bits, so there is no out-of-range case.
//     Counter is 4 bits and never underflows.
// TESTING
//   1. WAIT_CYCLES=1: ld_we writes 16'h1234 to 5 while IDLE; then CPU read of 5
//      -> ack 2 cycles after req is sampled, rdata=16'h1234, ack width exactly 1.
//   2. CPU write of 16'hBEEF to 12'h010, then read of 12'h010 -> second ack
//      returns 16'hBEEF; rdata between the two acks keeps its previous value.
//   3. io_in=16'h00A5, read of IO_ADDR -> rdata=16'h00A5; write 16'h5A5A to
//      IO_ADDR -> io_out=16'h5A5A after ack, RAM[IO_ADDR] unchanged.
//   4. ld_we and req both high in IDLE -> loader write done, no ack that cycle;
//      CPU ack follows WAIT_CYCLES+1 cycles after req is next sampled.
//   5. rst_n low during WAIT of a write of 16'h7777 -> ack never pulses,
//      io_out=0, rdata=0, target word unchanged, busy=0 immediately.
//   6. WAIT_CYCLES=0 and WAIT_CYCLES=15 builds: back-to-back reads with req held
//      high -> ack every 2 and every 17 cycles respectively.

Source files
------------

// File: rtl/simple_mem_responder.sv
// -----------------------------------------------------------------------------
// simple_mem_responder
//   Memory-side responder for the SIMPLE multi-phase CPU. The CPU issues one
//   read or write at a time. The responder inserts WAIT_CYCLES wait states and
//   then pulses ack for one cycle. Behind the port sit three things:
//     - the unified instruction/data RAM,
//     - a memory-mapped I/O word at IO_ADDR (reads return io_in, writes load
//       io_out),
//     - a program-loader write port that is usable whenever the FSM is idle.
//
// Ports
//   clk, rst_n        clock (posedge) and asynchronous active-low reset
//   req, we           CPU request (held until ack) and write select
//   addr, wdata       CPU word address and write data, sampled with req
//   rdata             read data, updated on read completion and held until
//                     the next read completes
//   ack               one-cycle completion pulse
//   busy              high while an access is in WAIT or ACK
//   ld_we, ld_addr,   loader write strobe, address and data; taken only while
//   ld_data           idle
//   ld_rdy            high when a loader write would be accepted this cycle
//   io_in             external input word, read at IO_ADDR
//   io_out            external output register, written at IO_ADDR
// -----------------------------------------------------------------------------
module simple_mem_responder #(
  parameter int                ADDR_W      = 12,
  parameter int                DATA_W      = 16,
  parameter int                WAIT_CYCLES = 1,
  parameter logic [ADDR_W-1:0] IO_ADDR     = ADDR_W'('hFFF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              busy,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_rdy,
  input  logic [DATA_W-1:0] io_in,
  output logic [DATA_W-1:0] io_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  // With no wait states the commit happens on the same edge that accepts the
  // request, so the commit must use the live request fields.
  localparam bit DIRECT = (WAIT_CYCLES == 0);

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        cnt;
  logic [3:0]        cnt_nxt;
  logic              commit;

  logic              accept;
  logic              ld_fire;

  logic              we_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] wdata_p0;

  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_io;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // The loader has priority over the CPU in IDLE.
  assign ld_fire = (state == S_IDLE) && ld_we;
  assign accept  = (state == S_IDLE) && req && !ld_we;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // FSM next-state logic; commit marks the edge that enters ACK
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          cnt_nxt = WAIT_INIT;
          if (DIRECT) begin
            state_nxt = S_ACK;
            commit    = 1'b1;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_nxt = S_ACK;
          commit    = 1'b1;
        end
      end
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    ack    = (state == S_ACK);
    busy   = (state != S_IDLE);
    ld_rdy = (state == S_IDLE);
  end

  // Stage p0: request fields captured at acceptance
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= we;
      addr_p0  <= addr;
      wdata_p0 <= wdata;
    end
  end

  assign c_we    = DIRECT ? we    : we_p0;
  assign c_addr  = DIRECT ? addr  : addr_p0;
  assign c_wdata = DIRECT ? wdata : wdata_p0;
  assign c_io    = (c_addr == IO_ADDR);

  // Single RAM write port shared by loader and CPU commit. They never collide:
  // loader writes need IDLE, and an IDLE-edge commit needs ld_we low.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = c_addr;
    ram_wdata = c_wdata;
    if (ld_fire) begin
      ram_we    = (ld_addr != IO_ADDR);
      ram_addr  = ld_addr;
      ram_wdata = ld_data;
    end else if (commit && c_we && !c_io) begin
      ram_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  // Commit stage: read data and I/O output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= '0;
      io_out <= '0;
    end else begin
      if (commit && !c_we) rdata <= c_io ? io_in : mem[c_addr];
      if (ld_fire && (ld_addr == IO_ADDR)) io_out <= ld_data;
      else if (commit && c_we && c_io)     io_out <= c_wdata;
    end
  end

endmodule
